mips32_mem_dump: RTL and testbench

- Readback engine for the pipe_MIPS32 data/instruction memory. It is the reader counterpart to the program/data preload path.
- After the processor raises HALTED, the engine reads a contiguous word range through a synchronous memory read port. It streams each word out with its address over a valid/ready interface.
- Result checking (e.g. Mem[120], Mem[121]) works from this stream instead of hierarchical peeks.

---
 rtl/mips32_mem_dump.sv | 197 +++++++++++++++++++
 tb/tb_mips32_mem_dump.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_mem_dump.sv
// rtl/mips32_mem_dump.sv - memory readback engine streaming a word range after HALTED
//
// Purpose:
//   Reads a contiguous range of words through a synchronous memory read port and
//   streams each word together with its address over a valid/ready interface.
//   Used to inspect pipe_MIPS32 memory contents once the processor has halted.
//
// Ports:
//   clk1         in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   halted       in   processor HALTED flag; a dump is only accepted while high
//   start        in   single-cycle dump request
//   start_addr   in   [AW] first word address, sampled on acceptance
//   count        in   [CW] number of words, sampled on acceptance
//   mem_rd_en    out  read strobe to memory
//   mem_addr     out  [AW] read address
//   mem_rd_data  in   [DW] read data, valid one cycle after mem_rd_en
//   dout_valid   out  stream word valid
//   dout_ready   in   sink ready
//   dout_data    out  [DW] word read
//   dout_addr    out  [AW] address of dout_data
//   dout_last    out  final word of the dump
//   busy         out  dump in progress
//   done         out  one-cycle pulse at dump completion
//   rejected     out  one-cycle pulse when start arrives while not halted

module mips32_mem_dump #(
  parameter int AW = 10,
  parameter int DW = 32,
  parameter int CW = 11
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          halted,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [CW-1:0] count,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rd_data,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [DW-1:0] dout_data,
  output logic [AW-1:0] dout_addr,
  output logic          dout_last,
  output logic          busy,
  output logic          done,
  output logic          rejected
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] issue_addr_q, issue_addr_d;
  logic [CW-1:0] issue_rem_q, issue_rem_d;
  logic          rejected_q, rejected_d;

  // One read can be outstanding in the memory pipeline at a time per cycle;
  // its address and last flag travel alongside it until the data returns.
  logic          inflight_q;
  logic [AW-1:0] inflight_addr_q;
  logic          inflight_last_q;

  // Two-entry output FIFO.
  logic [DW-1:0] fifo_data_q [2];
  logic [AW-1:0] fifo_addr_q [2];
  logic [1:0]    fifo_last_q;
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    fifo_cnt_q;

  logic          push;
  logic          pop;
  logic          issue;
  logic          head_last;
  logic [2:0]    committed;

  assign push      = inflight_q;
  assign dout_valid = (fifo_cnt_q != 2'd0);
  assign pop       = dout_valid && dout_ready;
  assign head_last = fifo_last_q[rd_ptr_q];

  // Entries that will still hold FIFO space after this cycle's pop: words
  // already queued plus the read in flight. A new read lands one cycle after
  // the next edge, so issuing is safe while fewer than two remain committed.
  // Counting this cycle's pop keeps one word per cycle with the sink ready.
  assign committed = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};

  assign issue = (state_q == READ) && (issue_rem_q != '0) && (committed < 3'd2);

  always_comb begin
    state_d      = state_q;
    issue_addr_d = issue_addr_q;
    issue_rem_d  = issue_rem_q;
    rejected_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (halted) begin
            issue_addr_d = start_addr;
            issue_rem_d  = count;
            state_d      = (count == '0) ? FINISH : READ;
          end else begin
            rejected_d = 1'b1;
          end
        end
      end
      READ: begin
        if (issue) begin
          issue_addr_d = issue_addr_q + AW'(1);
          issue_rem_d  = issue_rem_q - CW'(1);
          if (issue_rem_q == CW'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && head_last) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      issue_addr_q <= '0;
      issue_rem_q  <= '0;
      rejected_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_addr_q <= issue_addr_d;
      issue_rem_q  <= issue_rem_d;
      rejected_q   <= rejected_d;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_addr_q <= issue_addr_q;
        inflight_last_q <= (issue_rem_q == CW'(1));
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_addr_q[0] <= '0;
      fifo_addr_q[1] <= '0;
      fifo_last_q    <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      fifo_cnt_q     <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= mem_rd_data;
        fifo_addr_q[wr_ptr_q] <= inflight_addr_q;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign mem_rd_en = issue;
  assign mem_addr  = issue ? issue_addr_q : '0;
  assign dout_data = dout_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign dout_addr = dout_valid ? fifo_addr_q[rd_ptr_q] : '0;
  assign dout_last = dout_valid && head_last;
  assign busy      = (state_q == READ) || (state_q == DRAIN);
  assign done      = (state_q == FINISH);
  assign rejected  = rejected_q;

endmodule

// File: tb/tb_mips32_mem_dump.sv
// tb/tb_mips32_mem_dump.sv - scoreboard testbench for mips32_mem_dump

module tb_mips32_mem_dump;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int CW = 11;

  logic          clk1 = 1'b0;
  logic          rst_n = 1'b0;
  logic          halted = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [CW-1:0] count = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data = '0;
  logic          dout_valid;
  logic          dout_ready = 1'b1;
  logic [DW-1:0] dout_data;
  logic [AW-1:0] dout_addr;
  logic          dout_last;
  logic          busy;
  logic          done;
  logic          rejected;

  always #5 clk1 = ~clk1;

  mips32_mem_dump #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .halted      (halted),
    .start       (start),
    .start_addr  (start_addr),
    .count       (count),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .dout_data   (dout_data),
    .dout_addr   (dout_addr),
    .dout_last   (dout_last),
    .busy        (busy),
    .done        (done),
    .rejected    (rejected)
  );

  logic [DW-1:0] mem [1024];

  always @(posedge clk1) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  end

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  exp_t exp_q[$];
  int   pop_cycles[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   rej_cnt = 0;
  int   words_seen = 0;
  int   n_issue_total = 0;
  int   n_valid_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic push_exp(input int a, input logic [DW-1:0] d, input bit l);
    exp_t e;
    e.a = AW'(a);
    e.d = d;
    e.l = l;
    exp_q.push_back(e);
  endtask

  always @(posedge clk1) cyc++;

  // Monitor: pops the scoreboard on every handshake, checks stall stability
  // and that no read is issued while two entries stay committed.
  int   issued = 0;
  int   consumed = 0;
  bit   prev_stall = 1'b0;
  logic [DW-1:0] prev_d;
  logic [AW-1:0] prev_a;
  logic          prev_l;
  exp_t mon_e;

  always @(negedge clk1) begin
    if (!rst_n) begin
      issued     = 0;
      consumed   = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(dout_valid), 32'd1);
        chk("stall_data", dout_data, prev_d);
        chk("stall_addr", 32'(dout_addr), 32'(prev_a));
        chk("stall_last", 32'(dout_last), 32'(prev_l));
      end
      if (mem_rd_en) begin
        n_issue_total++;
        chk("issue_room", 32'((issued - consumed - int'(dout_valid && dout_ready)) < 2), 32'd1);
      end
      if (dout_valid) n_valid_total++;
      if (done) done_cnt++;
      if (rejected) rej_cnt++;
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got addr %0d data 0x%0h, expected no word", dout_addr, dout_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("word_addr", 32'(dout_addr), 32'(mon_e.a));
          chk("word_data", dout_data, mon_e.d);
          chk("word_last", 32'(dout_last), 32'(mon_e.l));
        end
        words_seen++;
        pop_cycles.push_back(cyc);
      end
      prev_stall = dout_valid && !dout_ready;
      prev_d     = dout_data;
      prev_a     = dout_addr;
      prev_l     = dout_last;
      issued     = issued + int'(mem_rd_en);
      consumed   = consumed + int'(dout_valid && dout_ready);
    end
  end

  task automatic do_start(input int a, input int c, input logic h);
    @(posedge clk1); #1;
    start_addr = AW'(a);
    count      = CW'(c);
    halted     = h;
    start      = 1'b1;
    @(posedge clk1); #1;
    start      = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, input bit toggle);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk1); #1;
      if (toggle) dout_ready = ((i % 3) != 2);
      @(negedge clk1);
      if (done) seen = 1'b1;
    end
    @(posedge clk1); #1;
    dout_ready = 1'b1;
    chk(name, 32'(seen), 32'd1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_mem_rd_en"}, 32'(mem_rd_en), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_dout_valid"}, 32'(dout_valid), 32'd0);
    chk({tag, "_dout_data"}, dout_data, 32'd0);
    chk({tag, "_dout_addr"}, 32'(dout_addr), 32'd0);
    chk({tag, "_dout_last"}, 32'(dout_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_rejected"}, 32'(rejected), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int  d0, i0, v0, r0, w0, lat;
    bit  reached;
    bit  pat [6];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
    mem[120]  = 32'd85;
    mem[121]  = 32'd130;
    mem[1022] = 32'hC0DE_03FE;
    mem[1023] = 32'hC0DE_03FF;
    mem[0]    = 32'hC0DE_0000;
    mem[1]    = 32'hC0DE_0001;
    for (int i = 0; i < 8; i++) mem[300 + i] = 32'h5A00_012C + 32'(i);

    // Reset state
    repeat (3) @(posedge clk1);
    @(negedge clk1);
    chk_outputs_zero("reset");
    @(posedge clk1); #1;
    rst_n = 1'b1;

    // Basic two-word dump, ready held high
    push_exp(120, 32'd85, 1'b0);
    push_exp(121, 32'd130, 1'b1);
    pop_cycles.delete();
    d0 = done_cnt;
    do_start(120, 2, 1'b1);
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk1);
      if (k == 0) begin
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_first_rd_en", 32'(mem_rd_en), 32'd1);
        chk("t1_first_rd_addr", 32'(mem_addr), 32'd120);
      end
      if (dout_valid) begin
        lat = k;
        break;
      end
    end
    chk("t1_first_valid_latency", 32'(lat), 32'd2);
    wait_done("t1_done_seen", 20, 1'b0);
    repeat (3) @(negedge clk1);
    chk("t1_done_once", 32'(done_cnt - d0), 32'd1);
    chk("t1_words", 32'(pop_cycles.size()), 32'd2);
    if (pop_cycles.size() == 2) chk("t1_consecutive", 32'(pop_cycles[1] - pop_cycles[0]), 32'd1);
    chk("t1_busy_after", 32'(busy), 32'd0);

    // Same dump with the sink stalling
    push_exp(120, 32'd85, 1'b0);
    push_exp(121, 32'd130, 1'b1);
    d0 = done_cnt;
    dout_ready = 1'b1;
    do_start(120, 2, 1'b1);
    for (int i = 1; i < 6; i++) begin
      @(posedge clk1); #1;
      dout_ready = pat[i];
    end
    wait_done("t2_done_seen", 20, 1'b0);
    repeat (3) @(negedge clk1);
    chk("t2_done_once", 32'(done_cnt - d0), 32'd1);
    chk("t2_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // Start while not halted is refused
    i0 = n_issue_total;
    d0 = done_cnt;
    do_start(120, 2, 1'b0);
    @(negedge clk1);
    chk("t3_rejected", 32'(rejected), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    @(negedge clk1);
    chk("t3_rejected_pulse", 32'(rejected), 32'd0);
    repeat (3) @(negedge clk1);
    chk("t3_no_issue", 32'(n_issue_total - i0), 32'd0);
    chk("t3_no_done", 32'(done_cnt - d0), 32'd0);

    // Zero-length dump
    i0 = n_issue_total;
    v0 = n_valid_total;
    do_start(500, 0, 1'b1);
    @(negedge clk1);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    @(negedge clk1);
    chk("t4_done_pulse", 32'(done), 32'd0);
    chk("t4_no_issue", 32'(n_issue_total - i0), 32'd0);
    chk("t4_no_valid", 32'(n_valid_total - v0), 32'd0);

    // Range wrapping past the top of memory; halted drops mid-dump
    push_exp(1022, 32'hC0DE_03FE, 1'b0);
    push_exp(1023, 32'hC0DE_03FF, 1'b0);
    push_exp(0, 32'hC0DE_0000, 1'b0);
    push_exp(1, 32'hC0DE_0001, 1'b1);
    d0 = done_cnt;
    do_start(1022, 4, 1'b1);
    halted = 1'b0;
    wait_done("t5_done_seen", 30, 1'b0);
    halted = 1'b1;
    repeat (2) @(negedge clk1);
    chk("t5_done_once", 32'(done_cnt - d0), 32'd1);
    chk("t5_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // Reset after three of eight words
    for (int k = 0; k < 8; k++) push_exp(300 + k, 32'h5A00_012C + 32'(k), k == 7);
    w0 = words_seen;
    do_start(300, 8, 1'b1);
    reached = 1'b0;
    for (int k = 0; k < 30 && !reached; k++) begin
      @(posedge clk1); #2;
      if (words_seen - w0 >= 3) reached = 1'b1;
    end
    chk("t6_three_words", 32'(reached), 32'd1);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("t6_reset");
    exp_q.delete();
    repeat (2) @(posedge clk1);
    #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk1);
    chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
    chk("t6_idle_busy", 32'(busy), 32'd0);

    // Fresh dump after reset with a stalling sink; a start mid-dump is ignored
    for (int k = 0; k < 8; k++) push_exp(300 + k, 32'h5A00_012C + 32'(k), k == 7);
    d0 = done_cnt;
    r0 = rej_cnt;
    do_start(300, 8, 1'b1);
    @(posedge clk1); #1;
    start_addr = AW'(5);
    count      = CW'(1);
    halted     = 1'b0;
    start      = 1'b1;
    @(posedge clk1); #1;
    start  = 1'b0;
    halted = 1'b1;
    wait_done("t7_done_seen", 80, 1'b1);
    repeat (3) @(negedge clk1);
    chk("t7_done_once", 32'(done_cnt - d0), 32'd1);
    chk("t7_no_reject_busy", 32'(rej_cnt - r0), 32'd0);
    chk("t7_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
